// File: rtl/decoder_n_reg.sv
// Buffered one-hot decoder: selects queue in a small circular buffer and
// leave it as a one-hot word, held for a handshake or shown for one cycle.
module decoder_n_reg #(
  parameter int SEL_W = 1,
  parameter int DEPTH = 2,
  parameter int PULSE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<SEL_W)-1:0] out_onehot,
  output logic [15:0]           dec_count
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [SEL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] occ;
  logic [15:0]      count_q;

  logic push;
  logic pop;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;

  // A full buffer never accepts, even when it is being drained this edge.
  assign in_ready  = (occ < OCC_FULL) && rst_n;
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && ((PULSE != 0) || out_ready);
  assign dec_count = count_q;

  assign head_nxt = (head == PTR_LAST) ? '0 : head + PTR_W'(1);
  assign tail_nxt = (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);

  always_comb begin
    out_onehot = '0;
    if (out_valid) begin
      out_onehot = OUT_W'(1) << mem[head];
    end
  end

  // Entries carry no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail <= tail_nxt;
      end
      if (pop) begin
        head <= head_nxt;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_n_reg.sv
// Directed bench for decoder_n_reg: three parameterisations share clock and
// reset, each exercised by hand-computed vectors.
module tb_decoder_n_reg;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  // A: SEL_W=3 DEPTH=2 hold
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0] a_in_sel;
  logic [7:0] a_onehot;
  logic [15:0] a_count;
  // B: SEL_W=2 DEPTH=3 pulse
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0] b_in_sel;
  logic [3:0] b_onehot;
  logic [15:0] b_count;
  // C: SEL_W=3 DEPTH=3 hold
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [2:0] c_in_sel;
  logic [7:0] c_onehot;
  logic [15:0] c_count;

  decoder_n_reg #(.SEL_W(3), .DEPTH(2), .PULSE(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_onehot(a_onehot), .dec_count(a_count)
  );

  decoder_n_reg #(.SEL_W(2), .DEPTH(3), .PULSE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_onehot(b_onehot), .dec_count(b_count)
  );

  decoder_n_reg #(.SEL_W(3), .DEPTH(3), .PULSE(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sel(c_in_sel),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_onehot(c_onehot), .dec_count(c_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_out_ready = 0; a_in_sel = '0;
    b_in_valid = 0; b_out_ready = 0; b_in_sel = '0;
    c_in_valid = 0; c_out_ready = 0; c_in_sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();

    // Outputs while held in reset
    chk("rst_valid",  a_out_valid, 0);
    chk("rst_onehot", a_onehot,    0);
    chk("rst_ready",  a_in_ready,  0);
    chk("rst_count",  a_count,     0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", a_in_ready, 1);

    // Single decode, sel=5, consumer ready
    a_in_valid = 1; a_in_sel = 3'd5; a_out_ready = 1;
    step();
    a_in_valid = 0; a_in_sel = 3'd0;
    chk("one_valid",  a_out_valid, 1);
    chk("one_onehot", a_onehot,    8'h20);
    step();
    chk("one_drained", a_out_valid, 0);
    chk("one_count",   a_count,     1);

    // Fill depth-2 hold buffer with consumer stalled; third push refused
    do_reset();
    step();
    a_in_valid = 1; a_in_sel = 3'd1;
    step();
    chk("fill_ready1", a_in_ready, 1);
    a_in_sel = 3'd6;
    step();
    chk("fill_full", a_in_ready, 0);
    a_in_sel = 3'd2;
    step();
    a_in_valid = 0; a_in_sel = 3'd7;
    chk("hold_onehot", a_onehot, 8'h02);
    step();
    chk("hold_onehot2", a_onehot, 8'h02);
    chk("hold_valid2",  a_out_valid, 1);
    a_out_ready = 1;
    #1;
    chk("drain0", a_onehot, 8'h02);
    step();
    chk("drain1", a_onehot, 8'h40);
    step();
    chk("drain_empty", a_out_valid, 0);
    chk("drain_count", a_count, 2);
    a_out_ready = 0;

    // Pulse mode: back-to-back 0,3,1 with out_ready low
    do_reset();
    step();
    b_in_valid = 1; b_in_sel = 2'd0;
    step();
    b_in_sel = 2'd3;
    chk("pulse0", b_onehot, 4'b0001);
    step();
    b_in_sel = 2'd1;
    chk("pulse1", b_onehot, 4'b1000);
    step();
    b_in_valid = 0;
    chk("pulse2", b_onehot, 4'b0010);
    step();
    chk("pulse_empty", b_out_valid, 0);
    chk("pulse_zero",  b_onehot,    0);
    chk("pulse_count", b_count,     3);

    // Streaming through depth 3: pointers wrap, occupancy stays 1
    do_reset();
    step();
    c_out_ready = 1;
    c_in_valid  = 1;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] v;
      v = 3'(i % 8);
      c_in_sel = v;
      step();
      chk("stream_onehot", c_onehot, 8'h01 << v);
      chk("stream_ready",  c_in_ready, 1);
    end
    c_in_valid = 0;
    step();
    chk("stream_empty", c_out_valid, 0);
    chk("stream_count", c_count, 10);

    // Fill depth 3, drain one, refill across the wrap, then reset mid-cycle
    c_out_ready = 0;
    c_in_valid  = 1;
    c_in_sel = 3'd4; step();
    c_in_sel = 3'd2; step();
    c_in_sel = 3'd7; step();
    c_in_valid = 0;
    chk("c_full", c_in_ready, 0);
    chk("c_head", c_onehot, 8'h10);
    c_out_ready = 1;
    step();
    c_out_ready = 0;
    chk("c_next", c_onehot, 8'h04);
    c_in_valid = 1; c_in_sel = 3'd1;
    step();
    c_in_valid = 0;
    chk("c_refull", c_in_ready, 0);
    chk("c_count11", c_count, 11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",  c_out_valid, 0);
    chk("midrst_onehot", c_onehot,    0);
    chk("midrst_count",  c_count,     0);
    chk("midrst_ready",  c_in_ready,  0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", c_in_ready, 1);
    c_out_ready = 1;
    step();
    chk("rel_no_stale", c_out_valid, 0);
    chk("rel_count",    c_count,     0);
    c_out_ready = 0;

    // Saturation of dec_count from 0xFFFE
    do_reset();
    step();
    force dut_a.count_q = 16'hFFFE;
    #1;
    release dut_a.count_q;
    #1;
    chk("sat_preset", a_count, 16'hFFFE);
    a_out_ready = 1;
    a_in_valid  = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_sel = 3'(i);
      step();
    end
    a_in_valid = 0;
    step();
    chk("sat_top",   a_count, 16'hFFFF);
    chk("sat_empty", a_out_valid, 0);
    a_in_valid = 1; a_in_sel = 3'd3;
    step();
    a_in_valid = 0;
    step();
    chk("sat_hold", a_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
